// File: rtl/simplerisc_pkg.sv
// Shared definitions for the simplerisc fetch path: widths, reset PC,
// the buffered fetch entry and the return-steering decisions.
package simplerisc_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned IMEM_AW  = 7;
  localparam int unsigned RESET_PC = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [IMEM_AW-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [2:0] {
    STEER_NONE,
    STEER_FLUSH,
    STEER_TO_OUT,
    STEER_TO_SKID,
    STEER_SHIFT,
    STEER_DRAIN,
    STEER_EMPTY
  } steer_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Decode-side handshake of the fetch sequencer: fetch is master, decode is slave.
interface imem_fetch_ctrl_if #(
  parameter int unsigned N = simplerisc_pkg::IMEM_AW
);
  import simplerisc_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [N-1:0]       out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/imem_fetch_ctrl_fetch_slot.sv
// One buffered fetch entry with a valid bit; load wins over clear.
module fetch_slot
  import simplerisc_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clka,
  input  logic   rst_n,
  input  logic   load,
  input  logic   clear,
  input  entry_t d,
  output logic   valid,
  output entry_t q
);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, tracks the one-cycle IM latency,
// buffers returns in out/skid slots and flushes wrong-path words on redirect.
module imem_fetch_ctrl #(
  parameter int unsigned      N        = simplerisc_pkg::IMEM_AW,
  parameter logic [N-1:0]     RESET_PC = N'(simplerisc_pkg::RESET_PC)
) (
  input  logic                               clka,
  input  logic                               rst_n,
  input  logic                               halt,
  input  logic                               redirect_valid,
  input  logic [N-1:0]                       redirect_pc,
  output logic [N-1:0]                       im_addr,
  input  logic [simplerisc_pkg::INSTR_W-1:0] im_data,
  imem_fetch_ctrl_if.master                  dec
);
  import simplerisc_pkg::*;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [N-1:0]       pc;
  } entry_t;

  logic [N-1:0] pc_q;
  logic [N-1:0] inflight_pc;
  logic         inflight;

  logic   out_v, skid_v;
  entry_t out_q, skid_q, out_d, ret_e;
  logic   out_load, out_clr, skid_load, skid_clr;

  logic       pop, issue;
  logic [1:0] occ;
  steer_t     steer;

  assign pop   = out_v & dec.out_ready;
  assign occ   = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, inflight};
  // occ never exceeds 2, so at most one more fetch may be outstanding
  assign issue = ~halt & ~redirect_valid & ((occ - {1'b0, pop}) <= 2'd1);
  assign ret_e = '{instr: im_data, pc: inflight_pc};

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (issue) begin
        pc_q        <= pc_q + 1'b1;
        inflight_pc <= pc_q;
      end
    end
  end

  always_comb begin
    steer = STEER_NONE;
    if (redirect_valid) begin
      steer = STEER_FLUSH;
    end else if (inflight) begin
      if ((~out_v | pop) & ~skid_v) steer = STEER_TO_OUT;
      else if (skid_v & pop)        steer = STEER_SHIFT;
      else                          steer = STEER_TO_SKID;
    end else if (pop) begin
      steer = skid_v ? STEER_DRAIN : STEER_EMPTY;
    end
  end

  always_comb begin
    out_load  = 1'b0;
    out_clr   = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    out_d     = ret_e;
    unique case (steer)
      STEER_FLUSH: begin
        out_clr  = 1'b1;
        skid_clr = 1'b1;
      end
      STEER_TO_OUT:  out_load = 1'b1;
      STEER_TO_SKID: skid_load = 1'b1;
      STEER_SHIFT: begin
        out_load  = 1'b1;
        out_d     = skid_q;
        skid_load = 1'b1;
      end
      STEER_DRAIN: begin
        out_load = 1'b1;
        out_d    = skid_q;
        skid_clr = 1'b1;
      end
      STEER_EMPTY: out_clr = 1'b1;
      default: ;
    endcase
  end

  fetch_slot #(.entry_t(entry_t)) u_out_slot (
    .clka  (clka),
    .rst_n (rst_n),
    .load  (out_load),
    .clear (out_clr),
    .d     (out_d),
    .valid (out_v),
    .q     (out_q)
  );

  fetch_slot #(.entry_t(entry_t)) u_skid_slot (
    .clka  (clka),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (ret_e),
    .valid (skid_v),
    .q     (skid_q)
  );

  assign im_addr       = pc_q;
  assign dec.out_valid = out_v;
  assign dec.out_instr = out_q.instr;
  assign dec.out_pc    = out_q.pc;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer in front of the synchronous instruction memory `IM`. It owns the program counter (PC), drives the memory address every cycle, and tracks the one-cycle read latency. It buffers returned words in a two-entry output stage so backpressure never drops an instruction. It also handles branch redirects by killing wrong-path fetches. It sits between `IM` and the decode stage.

## Interface
- `N`, 7, memory address width in words (matches `IM` depth 2^N)
- `RESET_PC`, 0, first word address fetched after reset
- `clka`  in  1  clock, shared with `IM`
- `rst_n`  in  1  asynchronous, active-low reset
- `halt`  in  1  stop issuing new fetches; buffered words still drain
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_pc`  in  N  target word address
- `im_addr`  out  N  to `IM` `addra`; equals `pc_q`
- `im_data`  in  32  from `IM` `douta`; valid one cycle after the address is sampled
- `out_valid`  out  1  instruction available to decode
- `out_ready`  in  1  decode accepts this cycle
- `out_instr`  out  32  instruction word
- `out_pc`  out  N  word address of `out_instr`

## Operation
- State:
  - `pc_q`: next address to issue.
  - `inflight` and `inflight_pc`: a read was issued last cycle; its data is on `im_data` now.
  - Out slot: `out_valid`, `out_instr`, `out_pc`.
  - Skid slot: `skid_valid`, `skid_instr`, `skid_pc`.
- `pop = out_valid & out_ready`.
- `occ = out_valid + skid_valid + inflight`. Range is 0..3.
- `issue = ~halt & ~redirect_valid & (occ - pop <= 1)`.
  - On issue: `pc_q <= pc_q + 1` (mod 2^N, wraps 2^N-1 -> 0), `inflight <= 1`, `inflight_pc <= pc_q`.
  - Otherwise: `inflight <= 0`. `IM` still reads `pc_q`, but the result is ignored.
- Return steering when `inflight = 1`:
  - Out slot empty or popping, skid empty: word goes to the out slot.
  - Skid full and popping: skid moves to out, the returning word goes to skid.
  - Otherwise: word goes to skid.
- Pop with no return: skid moves to out if `skid_valid`, else `out_valid <= 0`.
- The out slot is never overwritten while `out_valid & ~out_ready`. The capacity rule above guarantees no word is lost.
- Redirect has the highest priority. In the redirect cycle:
  - `pc_q <= redirect_pc`.
  - `out_valid`, `skid_valid` and `inflight` are cleared next cycle; the returning word is discarded.
  - No issue occurs.
  - A `pop` in the same cycle counts as consumed by decode.
- `halt` does not flush anything. A redirect during `halt` updates `pc_q` and flushes, and issue stays blocked until `halt` drops.

## Timing
- Reset (async assert, any cycle, including mid-fetch): `pc_q = RESET_PC`, `inflight = 0`, `out_valid = 0`, `skid_valid = 0`, `out_instr = 0`, `out_pc = 0`, `im_addr = RESET_PC`.
- First clock edge after `rst_n` rises: issue `RESET_PC`. First `out_valid` is 2 edges after release.
- Issue-to-`out_valid` latency is 2 cycles: the issue edge, then the capture edge.
- Steady state with `out_ready = 1` and no halt: one instruction per cycle, consecutive `out_pc`.
- Redirect asserted in cycle t:
  - Cycle t+1: `im_addr = redirect_pc`, issue.
  - Cycle t+3: `out_valid` with `out_pc = redirect_pc`.
  - Cycles t+1 and t+2: `out_valid = 0`.
- `out_ready` low for k cycles: at most 2 words are held (out + skid). Issue stalls while `occ - pop = 2`. When ready returns, delivery resumes with no gap and no duplicate.
- All outputs are registered except `im_addr`, which is a direct copy of the `pc_q` register.

## Structure
- Shared package `simplerisc_pkg`:
  - `INSTR_W = 32`
  - default `IMEM_AW = 7`
  - `RESET_PC`
  - a packed `fetch_entry_t` of `{instr[31:0], pc[N-1:0]}`
- One sub-module, `fetch_slot`: holds one `fetch_entry_t` plus a valid bit, with load/clear controls. It is instantiated twice, for the out slot and the skid slot.
- PC logic, the occupancy/issue equation and the steering mux live at the top level.

## Test plan
- Reset release, `IM` preloaded with `mem[i] = 0xA000_0000 + i`, `out_ready = 1`:
  - `out_valid` first high 2 cycles after release.
  - Delivers `out_pc` 0, 1, 2, … with matching `out_instr` every cycle.
- Backpressure: hold `out_ready = 0` for 5 cycles at `out_pc = 3`, then release:
  - `out_pc = 3` is held stable for the 5 cycles.
  - After release, the sequence continues 3, 4, 5, … with no skip or duplicate.
  - `im_addr` advances by at most 2 past 3 during the stall.
- Redirect to 0x40 while `out_valid` and `inflight` are both set:
  - `out_valid` low for 2 cycles.
  - Then `out_pc` 0x40, 0x41, …; no stale word appears.
- Redirect coinciding with `out_valid & out_ready` and a full skid slot:
  - The popped word counts as consumed.
  - The skid word is discarded.
  - The next delivered `out_pc` is the redirect target.
- Wrap: redirect to 0x7E with `N = 7` -> delivers 0x7E, 0x7F, 0x00, 0x01.
- `halt` for 4 cycles mid-stream, then `rst_n` pulsed low asynchronously between clock edges:
  - During halt, buffered words drain and then `out_valid = 0`.
  - On reset, outputs clear immediately.
  - After release, fetch restarts at `RESET_PC`.
